fdiv_fps: RTL and testbench

- Iterative single-precision mantissa/exponent divider for the FPU.
- Computes rs1/rs2 for finite, nonzero operands and writes the unrounded result in the 35-bit pre-round format. The shared FP rounding stage reads that format.
- This block is a producer on the pre-round interface.
- NaN, Inf and zero operands are filtered upstream by the FPU operation selector. This block never sees them.

---
 rtl/fdiv_fps_pkg.sv | 43 ++++
 rtl/fdiv_fps_if.sv | 23 ++
 rtl/fdiv_fps_lzc.sv | 15 +
 rtl/fdiv_fps.sv | 131 +++++++++++++
 tb/tb_fdiv_fps.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fdiv_fps_pkg.sv
// Shared FP definitions for the divider: pre-round field layout, bias constants,
// FSM encoding and the exponent saturation helper used when packing results.
package fdiv_fps_pkg;

    localparam int RES_W          = 35;
    localparam int SIGN           = 34;
    localparam int EXP_MSB        = 33;
    localparam int EXP_LSB        = 25;
    localparam int FRAC_MSB       = 24;
    localparam int FRAC_LSB       = 2;
    localparam int GUARD          = 1;
    localparam int STICKY         = 0;

    localparam int FP_BIAS        = 127;
    localparam int FP_EXP_OVF     = 255;
    localparam int FDIV_ITER      = 26;
    localparam int FDIV_STALL_CNT = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_PACK = 2'd2
    } state_e;

    typedef struct packed {
        logic        sign;
        logic [8:0]  exp;
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
    } preround_t;

    // Clamp a 10-bit signed exponent into the 9-bit two's complement field.
    function automatic logic [8:0] sat_exp(input logic signed [9:0] e);
        if (e > $signed(10'(FP_EXP_OVF)))
            return 9'(FP_EXP_OVF);
        else if (e < -10'sd256)
            return 9'h100;
        else
            return e[8:0];
    endfunction

endpackage

// File: rtl/fdiv_fps_if.sv
// Operand/result interface between the FPU operation selector and the divider.
interface fdiv_fps_if;
    import fdiv_fps_pkg::*;

    logic             start_i;
    logic             flush_i;
    logic [31:0]      rs1_i;
    logic [31:0]      rs2_i;
    logic             busy_o;
    logic             done_o;
    logic [RES_W-1:0] res_o;

    modport master (
        output start_i, flush_i, rs1_i, rs2_i,
        input  busy_o, done_o, res_o
    );

    modport slave (
        input  start_i, flush_i, rs1_i, rs2_i,
        output busy_o, done_o, res_o
    );

endinterface

// File: rtl/fdiv_fps_lzc.sv
// fp_lzc23: combinational leading-zero count of a 23-bit fraction (23 when all zero).
module fp_lzc23 (
    input  logic [22:0] frac,
    output logic [4:0]  cnt
);

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        cnt = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (frac[i]) cnt = 5'(22 - i);
        end
    end

endmodule

// File: rtl/fdiv_fps.sv
// Iterative restoring single-precision divider producing the unrounded 35-bit
// pre-round result for the shared FP rounding stage.
module fdiv_fps
    import fdiv_fps_pkg::*;
#(
    parameter int ITER = FDIV_ITER
) (
    input  logic       clk,
    input  logic       rst_n,
    fdiv_fps_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_e              state;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;
    logic [23:0]         mb_q;
    logic [24:0]         rem_q;
    logic [ITER-1:0]     q_q;
    logic signed [9:0]   e_q;
    logic                busy_q;
    logic                done_q;
    preround_t           res_q;

    logic [4:0]          lzc_a, lzc_b;
    logic [23:0]         ma_n, mb_n;
    logic signed [9:0]   ea_n, eb_n, e_n;
    logic                ge;
    logic [23:0]         diff;
    logic signed [9:0]   e_adj;
    preround_t           pack_n;

    fp_lzc23 u_lzc_a (.frac(bus.rs1_i[22:0]), .cnt(lzc_a));
    fp_lzc23 u_lzc_b (.frac(bus.rs2_i[22:0]), .cnt(lzc_b));

    // Normalise both operands so bit23 is set; subnormals carry a non-positive exponent.
    always_comb begin
        if (bus.rs1_i[30:23] == 8'd0) begin
            ma_n = {1'b0, bus.rs1_i[22:0]} << (lzc_a + 5'd1);
            ea_n = -$signed({5'b0, lzc_a});
        end else begin
            ma_n = {1'b1, bus.rs1_i[22:0]};
            ea_n = $signed({2'b0, bus.rs1_i[30:23]});
        end
        if (bus.rs2_i[30:23] == 8'd0) begin
            mb_n = {1'b0, bus.rs2_i[22:0]} << (lzc_b + 5'd1);
            eb_n = -$signed({5'b0, lzc_b});
        end else begin
            mb_n = {1'b1, bus.rs2_i[22:0]};
            eb_n = $signed({2'b0, bus.rs2_i[30:23]});
        end
        e_n = ea_n - eb_n + $signed(10'(FP_BIAS));
    end

    // rem < 2*mb always holds, so the difference fits in 24 bits.
    assign ge   = rem_q >= {1'b0, mb_q};
    assign diff = 24'(rem_q - {1'b0, mb_q});

    always_comb begin
        pack_n.sign = sign_q;
        if (q_q[ITER-1]) begin
            pack_n.frac   = q_q[ITER-2 -: 23];
            pack_n.guard  = q_q[1];
            pack_n.sticky = q_q[0] | (|rem_q);
            e_adj         = e_q;
        end else begin
            pack_n.frac   = q_q[ITER-3 -: 23];
            pack_n.guard  = q_q[0];
            pack_n.sticky = |rem_q;
            e_adj         = e_q - 10'sd1;
        end
        pack_n.exp = sat_exp(e_adj);
    end

    // NOTE: datapath registers are flops, not a memory array, so they all take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            mb_q   <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            e_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
            done_q <= 1'b0;
            if (bus.flush_i) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            sign_q <= bus.rs1_i[31] ^ bus.rs2_i[31];
                            mb_q   <= mb_n;
                            rem_q  <= {1'b0, ma_n};
                            e_q    <= e_n;
                            q_q    <= '0;
                            cnt_q  <= CNT_W'(ITER);
                            busy_q <= 1'b1;
                            state  <= ST_ITER;
                        end
                    end
                    ST_ITER: begin
                        rem_q <= ge ? {diff, 1'b0} : {rem_q[23:0], 1'b0};
                        q_q   <= {q_q[ITER-2:0], ge};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) state <= ST_PACK;
                    end
                    ST_PACK: begin
                        res_q  <= pack_n;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.res_o  = res_q;

endmodule

// File: tb/tb_fdiv_fps.sv
// Directed self-checking bench for fdiv_fps: results, latency, handshake, flush and reset.
module tb_fdiv_fps;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   c0  = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt;

    localparam logic [34:0] R62  = {1'b0, 9'd128, 23'h400000, 1'b0, 1'b0};
    localparam logic [34:0] R13  = {1'b0, 9'd125, 23'h2AAAAA, 1'b1, 1'b1};
    localparam logic [34:0] RSUB = {1'b0, 9'h1EA, 23'h000000, 1'b0, 1'b0};
    localparam logic [34:0] RNEG = {1'b1, 9'd128, 23'h000000, 1'b0, 1'b0};
    localparam logic [34:0] RBIG = {1'b0, 9'd255, 23'h7FFFFF, 1'b0, 1'b0};
    localparam logic [34:0] RSML = {1'b0, 9'h16A, 23'h000000, 1'b1, 1'b1};

    fdiv_fps_if bus ();

    fdiv_fps dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        c0 = cyc;
        check({tag, "_busy"}, 35'(bus.busy_o), 35'd1);
    endtask

    // Bounded wait; done must arrive 27 edges after the start edge.
    task automatic wait_done(input string tag, input logic [34:0] exp_res);
        while (bus.done_o !== 1'b1 && (cyc - c0) < 40) @(negedge clk);
        check({tag, "_done"}, 35'(bus.done_o), 35'd1);
        check({tag, "_lat"}, 35'(cyc - c0), 35'd27);
        check({tag, "_res"}, bus.res_o, exp_res);
        check({tag, "_busy_low"}, 35'(bus.busy_o), 35'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        #12;
        check("rst_busy", 35'(bus.busy_o), 35'd0);
        check("rst_done", 35'(bus.done_o), 35'd0);
        check("rst_res", bus.res_o, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op("div6_2", 32'h40C00000, 32'h40000000);
        wait_done("div6_2", R62);
        @(negedge clk);
        check("div6_2_pulse", 35'(bus.done_o), 35'd0);
        check("div6_2_hold", bus.res_o, R62);

        start_op("div1_3", 32'h3F800000, 32'h40400000);
        check("div1_3_res_kept", bus.res_o, R62);
        wait_done("div1_3", R13);

        start_op("sub", 32'h00000001, 32'h3F800000);
        wait_done("sub", RSUB);

        start_op("neg", 32'hBF800000, 32'h3F000000);
        wait_done("neg", RNEG);

        start_op("ovf", 32'h7F7FFFFF, 32'h00000001);
        wait_done("ovf", RBIG);

        start_op("small", 32'h00000001, 32'h7F7FFFFF);
        wait_done("small", RSML);

        // start held high while operands change: only the first pair counts.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rs1_i   = 32'h40C00000;
        bus.rs2_i   = 32'h40000000;
        @(negedge clk);
        c0 = cyc;
        bus.rs1_i = 32'h3F800000;
        bus.rs2_i = 32'h40400000;
        while ((cyc - c0) < 10) begin
            @(negedge clk);
            bus.rs1_i = bus.rs1_i + 32'h00100000;
        end
        bus.start_i = 1'b0;
        wait_done("hold", R62);

        // Back-to-back: new start in the done cycle.
        bus.start_i = 1'b1;
        bus.rs1_i   = 32'hBF800000;
        bus.rs2_i   = 32'h3F000000;
        @(negedge clk);
        bus.start_i = 1'b0;
        c0 = cyc;
        check("b2b_busy", 35'(bus.busy_o), 35'd1);
        check("b2b_res_kept", bus.res_o, R62);
        wait_done("b2b", RNEG);

        start_op("flush", 32'h3F800000, 32'h40400000);
        while ((cyc - c0) < 10) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_busy", 35'(bus.busy_o), 35'd0);
        done_cnt = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) done_cnt++;
        end
        check("flush_no_done", 35'(done_cnt), 35'd0);
        check("flush_res_kept", bus.res_o, RNEG);

        // flush wins over a simultaneous start.
        bus.flush_i = 1'b1;
        bus.start_i = 1'b1;
        bus.rs1_i   = 32'h40C00000;
        bus.rs2_i   = 32'h40000000;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        check("flush_prio_busy", 35'(bus.busy_o), 35'd0);

        start_op("rst_mid", 32'h40C00000, 32'h40000000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 35'(bus.busy_o), 35'd0);
        check("rst_mid_done", 35'(bus.done_o), 35'd0);
        check("rst_mid_res", bus.res_o, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op("after_rst", 32'h3F800000, 32'h40400000);
        wait_done("after_rst", R13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
